// File: rtl/bypass_lane_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bypass_lane_driver_pkg
// Description : Shared bypass-network types. bypassPkt is the per-lane
//               forwarding packet consumed by every operand comparator.
//               vlResultPkt is one buffered variable-latency result.
// Revision    : 1.0 - initial release
// ============================================================================
package bypass_lane_driver_pkg;

  localparam int SIZE_DATA         = 64;
  localparam int SIZE_PHYSICAL_LOG = 7;

  typedef struct packed {
    logic                         valid;
    logic [SIZE_PHYSICAL_LOG-1:0] tag;
    logic [SIZE_DATA-1:0]         data;
  } bypassPkt;

  typedef struct packed {
    logic [SIZE_PHYSICAL_LOG-1:0] tag;
    logic [SIZE_DATA-1:0]         data;
  } vlResultPkt;

endpackage
`default_nettype wire

// File: rtl/bypass_lane_driver_fifo.sv
`default_nettype none
// ============================================================================
// Module      : result_fifo
// Description : Circular buffer holding variable-latency results that lost
//               arbitration. Pointers wrap modulo DEPTH (power of two).
//               Push and pop in the same cycle at full are legal: the pop
//               frees the slot being written.
// Ports       : clk, reset     - clock, synchronous active-high reset
//               flush          - empties the buffer at the next edge
//               push / wr_data - enqueue request and payload
//               pop  / rd_data - dequeue request and current head
//               count          - current occupancy
//               count_next     - occupancy after this edge
//               full / empty   - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_r;

  logic do_push;
  logic do_pop;

  assign do_push    = push && !flush && !reset;
  assign do_pop     = pop  && !flush && !reset;
  assign count      = count_r;
  assign full       = (count_r == DEPTH_C);
  assign empty      = (count_r == '0);
  assign rd_data    = mem[rd_ptr];

  always_comb begin
    count_next = count_r;
    if (reset || flush) begin
      count_next = '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_next = count_r + 1'b1;
        2'b01:   count_next = count_r - 1'b1;
        default: count_next = count_r;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_r <= count_next;
    end
  end

  // Storage needs no reset; entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      assert (!(do_push && full && !do_pop)) else $error("result_fifo overflow");
      assert (!(do_pop && empty))            else $error("result_fifo underflow");
    end
  end

endmodule
`default_nettype wire

// File: rtl/bypass_lane_driver.sv
`default_nettype none
// ============================================================================
// Module      : bypass_lane_driver
// Description : Per-lane producer of the bypass packet. Merges a fixed-latency
//               stream (never stalls) with a variable-latency handshaked
//               stream buffered in result_fifo, emitting at most one
//               registered result per cycle to the bypass network and to the
//               register-file write port.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               flush_i              - squashes all in-flight state
//               fxValid_i/Tag/Data   - fixed-latency result (always accepted)
//               vlValid_i/Tag/Data   - variable-latency result
//               vlReady_o            - variable-latency ready (combinational)
//               bypassPacket_o       - registered bypass packet
//               rfWrEn/Addr/Data_o   - mirrors of bypassPacket_o
//               almostFull_o         - registered, count >= DEPTH-1
// Revision    : 1.0 - initial release
// ============================================================================
module bypass_lane_driver
  import bypass_lane_driver_pkg::*;
#(
  parameter int DATA_WIDTH = SIZE_DATA,
  parameter int TAG_WIDTH  = SIZE_PHYSICAL_LOG,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic                  fxValid_i,
  input  logic [TAG_WIDTH-1:0]  fxTag_i,
  input  logic [DATA_WIDTH-1:0] fxData_i,
  input  logic                  vlValid_i,
  output logic                  vlReady_o,
  input  logic [TAG_WIDTH-1:0]  vlTag_i,
  input  logic [DATA_WIDTH-1:0] vlData_i,
  output bypassPkt              bypassPacket_o,
  output logic                  rfWrEn_o,
  output logic [TAG_WIDTH-1:0]  rfWrAddr_o,
  output logic [DATA_WIDTH-1:0] rfWrData_o,
  output logic                  almostFull_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(DEPTH - 1);

  vlResultPkt       fifo_wr;
  vlResultPkt       fifo_rd;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] fifo_count_next;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;

  logic             vl_hs;
  logic             sel_valid;
  logic [TAG_WIDTH-1:0]  sel_tag;
  logic [DATA_WIDTH-1:0] sel_data;

  bypassPkt         pkt_r;
  logic             almost_full_r;

  assign vlReady_o = (fifo_count < DEPTH_C) && !flush_i && !reset;
  assign vl_hs     = vlValid_i && vlReady_o;

  assign fifo_wr.tag  = vlTag_i;
  assign fifo_wr.data = vlData_i;

  // Priority: fixed-latency, then buffered head, then vl pass-through.
  // An accepted vl result is buffered whenever it does not go straight out.
  always_comb begin
    sel_valid = 1'b0;
    sel_tag   = fxTag_i;
    sel_data  = fxData_i;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (fxValid_i) begin
      sel_valid = 1'b1;
      fifo_push = vl_hs;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_tag   = fifo_rd.tag;
      sel_data  = fifo_rd.data;
      fifo_pop  = 1'b1;
      fifo_push = vl_hs;
    end else if (vl_hs) begin
      sel_valid = 1'b1;
      sel_tag   = vlTag_i;
      sel_data  = vlData_i;
    end
  end

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(vlResultPkt))
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush_i),
    .push       (fifo_push),
    .wr_data    (fifo_wr),
    .pop        (fifo_pop),
    .rd_data    (fifo_rd),
    .count      (fifo_count),
    .count_next (fifo_count_next),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Idle cycles and flushes drop valid only; tag/data keep their last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_r         <= '0;
      almost_full_r <= 1'b0;
    end else if (flush_i) begin
      pkt_r.valid   <= 1'b0;
      almost_full_r <= 1'b0;
    end else begin
      pkt_r.valid   <= sel_valid;
      if (sel_valid) begin
        pkt_r.tag  <= sel_tag;
        pkt_r.data <= sel_data;
      end
      almost_full_r <= (fifo_count_next >= AF_C);
    end
  end

  assign bypassPacket_o = pkt_r;
  assign rfWrEn_o       = pkt_r.valid;
  assign rfWrAddr_o     = pkt_r.tag;
  assign rfWrData_o     = pkt_r.data;
  assign almostFull_o   = almost_full_r;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!$isunknown(fxValid_i)) else $error("fxValid_i is X");
      assert (!(fifo_full && fifo_push && !fifo_pop)) else $error("vl push at full");
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bypass_lane_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_bypass_lane_driver
// Description : Self-checking bench for bypass_lane_driver. A queue-based
//               model tracks buffered vl results and the expected registered
//               packet; directed scenarios plus a randomized run compare it
//               against the DUT every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bypass_lane_driver;
  import bypass_lane_driver_pkg::*;

  localparam int DW    = 64;
  localparam int TW    = 7;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          fxv;
  logic [TW-1:0] fxt;
  logic [DW-1:0] fxd;
  logic          vlv;
  logic [TW-1:0] vlt;
  logic [DW-1:0] vld;

  logic          vl_ready;
  bypassPkt      pkt;
  logic          rf_en;
  logic [TW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          af;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [TW+DW-1:0] vlq[$];
  logic             exp_valid;
  logic [TW-1:0]    exp_tag;
  logic [DW-1:0]    exp_data;
  logic             exp_af;

  wire [144:0] dut_vec = {pkt.valid, pkt.tag, pkt.data, rf_en, rf_addr, rf_data, af};

  always #5 clk = ~clk;

  bypass_lane_driver #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (rst),
    .flush_i        (flush),
    .fxValid_i      (fxv),
    .fxTag_i        (fxt),
    .fxData_i       (fxd),
    .vlValid_i      (vlv),
    .vlReady_o      (vl_ready),
    .vlTag_i        (vlt),
    .vlData_i       (vld),
    .bypassPacket_o (pkt),
    .rfWrEn_o       (rf_en),
    .rfWrAddr_o     (rf_addr),
    .rfWrData_o     (rf_data),
    .almostFull_o   (af)
  );

  function automatic logic [144:0] exp_vec();
    return {exp_valid, exp_tag, exp_data, exp_valid, exp_tag, exp_data, exp_af};
  endfunction

  function automatic logic model_ready();
    return !rst && !flush && (vlq.size() < DEPTH);
  endfunction

  task automatic idle_inputs();
    flush = 1'b0; fxv = 1'b0; vlv = 1'b0;
  endtask

  // Advances the model by one edge using the current inputs, then clocks.
  task automatic clock_edge();
    logic hs;
    logic [TW+DW-1:0] e;
    hs = vlv && model_ready();
    if (rst) begin
      vlq.delete();
      exp_valid = 1'b0; exp_tag = '0; exp_data = '0; exp_af = 1'b0;
    end else if (flush) begin
      vlq.delete();
      exp_valid = 1'b0; exp_af = 1'b0;
    end else begin
      if (fxv) begin
        exp_valid = 1'b1; exp_tag = fxt; exp_data = fxd;
        if (hs) vlq.push_back({vlt, vld});
      end else if (vlq.size() != 0) begin
        e = vlq.pop_front();
        exp_valid = 1'b1; exp_tag = e[TW+DW-1:DW]; exp_data = e[DW-1:0];
        if (hs) vlq.push_back({vlt, vld});
      end else if (hs) begin
        exp_valid = 1'b1; exp_tag = vlt; exp_data = vld;
      end else begin
        exp_valid = 1'b0;
      end
      exp_af = (vlq.size() >= DEPTH - 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    fxt = '0; fxd = '0; vlt = '0; vld = '0;
    repeat (3) clock_edge();
    tests++;
    if (dut_vec !== 145'd0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0", dut_vec);
    end
    tests++;
    if (vl_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready_low: got %b expected 0", vl_ready);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (vl_ready !== 1'b1) begin
      fails++; $display("FAIL release_ready: got %b expected 1", vl_ready);
    end
  endtask

  task automatic test_pass_through();
    idle_inputs();
    vlv = 1'b1; vlt = 7'h12; vld = 64'hDEAD;
    clock_edge();
    tests++;
    if (dut_vec !== exp_vec() || pkt.valid !== 1'b1 || pkt.tag !== 7'h12 ||
        pkt.data !== 64'hDEAD || rf_en !== 1'b1) begin
      fails++; $display("FAIL pass_through: got %h expected %h", dut_vec, exp_vec());
    end
    idle_inputs();
    clock_edge();
    tests++;
    if (dut_vec !== exp_vec() || pkt.valid !== 1'b0 || pkt.tag !== 7'h12) begin
      fails++; $display("FAIL idle_hold: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_contention();
    idle_inputs();
    fxv = 1'b1; fxt = 7'h05; fxd = 64'h1;
    vlv = 1'b1; vlt = 7'h06; vld = 64'h2;
    clock_edge();
    tests++;
    if (dut_vec !== exp_vec() || pkt.tag !== 7'h05 || pkt.valid !== 1'b1) begin
      fails++; $display("FAIL contention_fx_first: got %h expected %h", dut_vec, exp_vec());
    end
    idle_inputs();
    clock_edge();
    tests++;
    if (dut_vec !== exp_vec() || pkt.tag !== 7'h06 || pkt.data !== 64'h2 || pkt.valid !== 1'b1) begin
      fails++; $display("FAIL contention_vl_second: got %h expected %h", dut_vec, exp_vec());
    end
    clock_edge();
    tests++;
    if (dut_vec !== exp_vec() || pkt.valid !== 1'b0) begin
      fails++; $display("FAIL contention_drained: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_fill_drain();
    int acc = 0;
    int emitted = 0;
    idle_inputs();
    fxv = 1'b1; vlv = 1'b1;
    for (int c = 0; c < 6; c++) begin
      fxt = 7'h40 + 7'(c); fxd = {$urandom, $urandom};
      vlt = 7'h20 + 7'(acc); vld = 64'hA0 + 64'(acc);
      tests++;
      if (vl_ready !== model_ready()) begin
        fails++; $display("FAIL fill_ready c%0d: got %b expected %b", c, vl_ready, model_ready());
      end
      if (model_ready()) acc++;
      clock_edge();
      tests++;
      if (dut_vec !== exp_vec() || af !== (acc >= 3)) begin
        fails++; $display("FAIL fill_out c%0d: got %h expected %h", c, dut_vec, exp_vec());
      end
    end
    tests++;
    if (vl_ready !== 1'b0) begin
      fails++; $display("FAIL full_ready_low: got %b expected 0", vl_ready);
    end
    fxv = 1'b0;
    for (int c = 0; c < 12; c++) begin
      vlv = (acc < 6);
      vlt = 7'h20 + 7'(acc); vld = 64'hA0 + 64'(acc);
      tests++;
      if (vl_ready !== model_ready()) begin
        fails++; $display("FAIL drain_ready c%0d: got %b expected %b", c, vl_ready, model_ready());
      end
      if (vlv && model_ready()) acc++;
      clock_edge();
      tests++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL drain_out c%0d: got %h expected %h", c, dut_vec, exp_vec());
      end
      if (pkt.valid === 1'b1) begin
        tests++;
        if (pkt.tag !== 7'h20 + 7'(emitted)) begin
          fails++; $display("FAIL drain_order: got %h expected %h", pkt.tag, 7'h20 + 7'(emitted));
        end
        emitted++;
      end
    end
    tests++;
    if (emitted != 6) begin
      fails++; $display("FAIL drain_count: got %0d expected 6", emitted);
    end
  endtask

  task automatic test_push_pop_wrap();
    int acc = 0;
    int emitted = 0;
    idle_inputs();
    fxv = 1'b1; vlv = 1'b1;
    for (int c = 0; c < 4; c++) begin
      fxt = 7'h60 + 7'(c); fxd = 64'(c);
      vlt = 7'h50 + 7'(acc); vld = {$urandom, $urandom};
      if (model_ready()) acc++;
      clock_edge();
      tests++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL wrap_fill c%0d: got %h expected %h", c, dut_vec, exp_vec());
      end
    end
    fxv = 1'b0;
    for (int c = 0; c < 14; c++) begin
      vlt = 7'h50 + 7'(acc); vld = {$urandom, $urandom};
      tests++;
      if (vl_ready !== model_ready()) begin
        fails++; $display("FAIL wrap_ready c%0d: got %b expected %b", c, vl_ready, model_ready());
      end
      if (model_ready()) acc++;
      clock_edge();
      tests++;
      if (dut_vec !== exp_vec() || pkt.tag !== 7'h50 + 7'(emitted)) begin
        fails++; $display("FAIL wrap_out c%0d: got %h expected %h", c, dut_vec, exp_vec());
      end
      emitted++;
    end
    idle_inputs();
    repeat (6) clock_edge();
    tests++;
    if (dut_vec !== exp_vec()) begin
      fails++; $display("FAIL wrap_settle: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    fxv = 1'b1; vlv = 1'b1;
    for (int c = 0; c < 3; c++) begin
      fxt = 7'h70 + 7'(c); fxd = 64'(c);
      vlt = 7'h28 + 7'(c); vld = 64'(c);
      clock_edge();
    end
    flush = 1'b1; vlt = 7'h2F;
    #1;
    tests++;
    if (vl_ready !== 1'b0) begin
      fails++; $display("FAIL flush_ready_low: got %b expected 0", vl_ready);
    end
    clock_edge();
    tests++;
    if (dut_vec !== exp_vec() || pkt.valid !== 1'b0 || af !== 1'b0) begin
      fails++; $display("FAIL flush_out: got %h expected %h", dut_vec, exp_vec());
    end
    idle_inputs();
    vlv = 1'b1; vlt = 7'h30; vld = 64'h3030;
    #1;
    tests++;
    if (vl_ready !== 1'b1) begin
      fails++; $display("FAIL post_flush_ready: got %b expected 1", vl_ready);
    end
    clock_edge();
    tests++;
    if (dut_vec !== exp_vec() || pkt.valid !== 1'b1 || pkt.tag !== 7'h30) begin
      fails++; $display("FAIL post_flush_pass: got %h expected %h", dut_vec, exp_vec());
    end
    idle_inputs();
    clock_edge();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 39) == 0);
      fxv   = ($urandom_range(0, 2) == 0);
      fxt   = 7'($urandom); fxd = {$urandom, $urandom};
      vlv   = ($urandom_range(0, 1) == 0);
      vlt   = 7'($urandom); vld = {$urandom, $urandom};
      #1;
      tests++;
      if (vl_ready !== model_ready()) begin
        fails++; $display("FAIL rand_ready c%0d: got %b expected %b", c, vl_ready, model_ready());
      end
      clock_edge();
      tests++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL rand_out c%0d: got %h expected %h", c, dut_vec, exp_vec());
      end
    end
    rst = 1'b0;
    idle_inputs();
    clock_edge();
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_contention();
    test_fill_drain();
    test_push_pop_wrap();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
